// File: rtl/rv_issue_pkg.sv
// Shared constants for the issue scheduler: legal queue depths, counter width
// helper and the bit layout of one packed reservation-station entry.
package rv_issue_pkg;

  localparam int unsigned Q_DEPTH_MIN = 8;
  localparam int unsigned Q_DEPTH_MID = 12;
  localparam int unsigned Q_DEPTH_MAX = 16;

  // Entry layout, LSB first: valid, ready, tag, payload.
  localparam int unsigned ENT_VALID_BIT = 0;
  localparam int unsigned ENT_READY_BIT = 1;
  localparam int unsigned ENT_TAG_LSB   = 2;

  function automatic int unsigned q_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ent_dat_lsb(input int unsigned tag_w);
    return ENT_TAG_LSB + tag_w;
  endfunction

  function automatic int unsigned ent_width(input int unsigned tag_w, input int unsigned dat_w);
    return ENT_TAG_LSB + tag_w + dat_w;
  endfunction

  function automatic bit q_depth_legal(input int unsigned depth);
    return (depth == Q_DEPTH_MIN) || (depth == Q_DEPTH_MID) || (depth == Q_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/rv_issue_prisel.sv
// Oldest-first priority select: one-hot of the lowest set condition bit and
// an AND-OR mux of the matching entry payload. Purely combinational.
module rv_issue_prisel
  import rv_issue_pkg::*;
#(
  parameter int unsigned Q_NUM_ENTRIES = 16,
  parameter int unsigned Q_DAT_WIDTH   = 7
) (
  input  logic [Q_NUM_ENTRIES-1:0]             cond,
  input  logic [Q_NUM_ENTRIES*Q_DAT_WIDTH-1:0] dat,
  output logic [Q_NUM_ENTRIES-1:0]             sel_c,
  output logic                                 any_c,
  output logic [Q_DAT_WIDTH-1:0]               sel_dat_c
);

  // Two's-complement trick isolates the lowest set bit.
  assign sel_c = cond & (~cond + Q_NUM_ENTRIES'(1));
  assign any_c = |cond;

  always_comb begin
    sel_dat_c = '0;
    for (int i = 0; i < int'(Q_NUM_ENTRIES); i++) begin
      sel_dat_c = sel_dat_c | (dat[i*Q_DAT_WIDTH +: Q_DAT_WIDTH] & {Q_DAT_WIDTH{sel_c[i]}});
    end
  end

endmodule

// File: rtl/rv_issue_sched.sv
// Age-ordered reservation-station queue with tag wakeup, oldest-ready select
// and a registered valid/ready issue stage. Define RV_ISSUE_FLUSH_EN for flush.
module rv_issue_sched
  import rv_issue_pkg::*;
#(
  parameter int unsigned Q_NUM_ENTRIES = 16,
  parameter int unsigned Q_DAT_WIDTH   = 7,
  parameter int unsigned Q_TAG_WIDTH   = 6,
  parameter int unsigned Q_CNT_WIDTH   = q_cnt_width(Q_NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   alloc_v,
  output logic                   alloc_rdy,
  input  logic [Q_DAT_WIDTH-1:0] alloc_dat,
  input  logic [Q_TAG_WIDTH-1:0] alloc_tag,
  input  logic                   alloc_src_rdy,
  input  logic                   wake_v,
  input  logic [Q_TAG_WIDTH-1:0] wake_tag,
  output logic                   issue_v,
  input  logic                   issue_rdy,
  output logic [Q_DAT_WIDTH-1:0] issue_dat,
`ifdef RV_ISSUE_FLUSH_EN
  input  logic                   flush,
`endif
  output logic [Q_CNT_WIDTH-1:0] q_cnt
);

  localparam int unsigned N       = Q_NUM_ENTRIES;
  localparam int unsigned ENT_W   = ent_width(Q_TAG_WIDTH, Q_DAT_WIDTH);
  localparam int unsigned DAT_LSB = ent_dat_lsb(Q_TAG_WIDTH);

  logic [ENT_W-1:0]           ent_q [N];
  logic [ENT_W-1:0]           ent_d [N];
  logic [Q_CNT_WIDTH-1:0]     cnt_q;
  logic [Q_CNT_WIDTH-1:0]     cnt_d;
  logic                       issue_v_d;
  logic [Q_DAT_WIDTH-1:0]     issue_dat_d;

  logic [N-1:0]               cond;
  logic [N-1:0]               sel;
  logic [N-1:0]               shift_mask;
  logic [N*Q_DAT_WIDTH-1:0]   dat_flat;
  logic [Q_DAT_WIDTH-1:0]     sel_dat;
  logic [Q_CNT_WIDTH-1:0]     wr_idx;
  logic                       any_rdy;
  logic                       load_en;
  logic                       pop;
  logic                       alloc_acc;
  logic                       alloc_wake;
  logic                       flush_c;

`ifdef RV_ISSUE_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Acceptance uses the registered count only; a same-cycle pop gives no credit.
  assign alloc_rdy = (cnt_q < Q_CNT_WIDTH'(N)) & ~flush_c;
  assign alloc_acc = alloc_v & alloc_rdy;
  assign q_cnt     = cnt_q;
  assign load_en   = ~issue_v | issue_rdy;
  assign pop       = load_en & any_rdy;
  assign alloc_wake = wake_v & (wake_tag == alloc_tag);

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      cond[i] = ent_q[i][ENT_VALID_BIT] & ent_q[i][ENT_READY_BIT];
      dat_flat[i*Q_DAT_WIDTH +: Q_DAT_WIDTH] = ent_q[i][DAT_LSB +: Q_DAT_WIDTH];
    end
  end

  rv_issue_prisel #(
    .Q_NUM_ENTRIES (N),
    .Q_DAT_WIDTH   (Q_DAT_WIDTH)
  ) u_prisel (
    .cond      (cond),
    .dat       (dat_flat),
    .sel_c     (sel),
    .any_c     (any_rdy),
    .sel_dat_c (sel_dat)
  );

  // Slots at and above the selected one take their upper neighbour on a pop.
  always_comb begin
    logic run;
    run = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      run           = run | sel[i];
      shift_mask[i] = run;
    end
  end

  // Queue next state: compact, then wakeup, then alloc write.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      ent_d[i] = ent_q[i];
    end
    cnt_d  = cnt_q + Q_CNT_WIDTH'(alloc_acc) - Q_CNT_WIDTH'(pop);
    wr_idx = pop ? (cnt_q - Q_CNT_WIDTH'(1)) : cnt_q;

    for (int i = 0; i < int'(N) - 1; i++) begin
      if (pop && shift_mask[i]) begin
        ent_d[i] = ent_q[i+1];
      end
    end
    if (pop && shift_mask[N-1]) begin
      ent_d[N-1] = '0;
    end

    for (int i = 0; i < int'(N); i++) begin
      if (wake_v && ent_d[i][ENT_VALID_BIT] &&
          (ent_d[i][ENT_TAG_LSB +: Q_TAG_WIDTH] == wake_tag)) begin
        ent_d[i][ENT_READY_BIT] = 1'b1;
      end
    end

    for (int i = 0; i < int'(N); i++) begin
      if (alloc_acc && (Q_CNT_WIDTH'(i) == wr_idx)) begin
        ent_d[i]                               = '0;
        ent_d[i][ENT_VALID_BIT]                = 1'b1;
        ent_d[i][ENT_READY_BIT]                = alloc_src_rdy | alloc_wake;
        ent_d[i][ENT_TAG_LSB +: Q_TAG_WIDTH]   = alloc_tag;
        ent_d[i][DAT_LSB +: Q_DAT_WIDTH]       = alloc_dat;
      end
    end

    if (flush_c) begin
      for (int i = 0; i < int'(N); i++) begin
        ent_d[i] = '0;
      end
      cnt_d = '0;
    end
  end

  // Issue register next state: load when empty or draining.
  always_comb begin
    issue_v_d   = issue_v;
    issue_dat_d = issue_dat;
    if (load_en) begin
      issue_v_d = any_rdy;
      if (any_rdy) begin
        issue_dat_d = sel_dat;
      end
    end
    if (flush_c) begin
      issue_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < int'(N); i++) begin
        ent_q[i] <= '0;
      end
      cnt_q     <= '0;
      issue_v   <= 1'b0;
      issue_dat <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        ent_q[i] <= ent_d[i];
      end
      cnt_q     <= cnt_d;
      issue_v   <= issue_v_d;
      issue_dat <= issue_dat_d;
    end
  end

endmodule

// File: tb/tb_rv_issue_sched.sv
// Scoreboard bench for rv_issue_sched: a queue-based reference model runs on
// the same inputs; a monitor compares state each cycle and issued payloads.
module tb_rv_issue_sched;

  localparam int unsigned QN = 16;
  localparam int unsigned DW = 7;
  localparam int unsigned TW = 6;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          alloc_v;
  logic          alloc_rdy;
  logic [DW-1:0] alloc_dat;
  logic [TW-1:0] alloc_tag;
  logic          alloc_src_rdy;
  logic          wake_v;
  logic [TW-1:0] wake_tag;
  logic          issue_v;
  logic          issue_rdy;
  logic [DW-1:0] issue_dat;
  logic [CW-1:0] q_cnt;
`ifdef RV_ISSUE_FLUSH_EN
  logic          flush;
`endif

  always #5 clk = ~clk;

  rv_issue_sched #(
    .Q_NUM_ENTRIES (QN),
    .Q_DAT_WIDTH   (DW),
    .Q_TAG_WIDTH   (TW),
    .Q_CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .alloc_v       (alloc_v),
    .alloc_rdy     (alloc_rdy),
    .alloc_dat     (alloc_dat),
    .alloc_tag     (alloc_tag),
    .alloc_src_rdy (alloc_src_rdy),
    .wake_v        (wake_v),
    .wake_tag      (wake_tag),
    .issue_v       (issue_v),
    .issue_rdy     (issue_rdy),
    .issue_dat     (issue_dat),
`ifdef RV_ISSUE_FLUSH_EN
    .flush         (flush),
`endif
    .q_cnt         (q_cnt)
  );

  // Reference model: an age-ordered list plus the issue register contents.
  typedef struct {
    logic [DW-1:0] dat;
    logic [TW-1:0] tag;
    bit            rdy;
  } ment_t;

  ment_t         mq[$];
  logic [DW-1:0] expq[$];
  bit            m_iv = 1'b0;
  logic [DW-1:0] m_idat = '0;
  bit            done = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic model_step();
    int    k;
    bit    acc;
    ment_t e;
    k   = -1;
    acc = alloc_v && (mq.size() < int'(QN));
    if (!m_iv || issue_rdy) begin
      foreach (mq[i]) if (k < 0 && mq[i].rdy) k = i;
      if (k >= 0) begin
        m_iv   = 1'b1;
        m_idat = mq[k].dat;
        expq.push_back(mq[k].dat);
        mq.delete(k);
      end else begin
        m_iv = 1'b0;
      end
    end
    if (wake_v) foreach (mq[i]) if (mq[i].tag == wake_tag) mq[i].rdy = 1'b1;
    if (acc) begin
      e.dat = alloc_dat;
      e.tag = alloc_tag;
      e.rdy = alloc_src_rdy || (wake_v && (wake_tag == alloc_tag));
      mq.push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mq.delete();
      expq.delete();
      m_iv   = 1'b0;
      m_idat = '0;
    end
`ifdef RV_ISSUE_FLUSH_EN
    else if (flush) begin
      mq.delete();
      expq.delete();
      m_iv = 1'b0;
    end
`endif
    else begin
      model_step();
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples after inputs for the coming edge have settled.
  initial begin
    bit   exp_ardy;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      #2;
      if (done) break;
      exp_ardy = (mq.size() < int'(QN));
`ifdef RV_ISSUE_FLUSH_EN
      if (flush) exp_ardy = 1'b0;
`endif
      check("issue_v", 32'(issue_v), 32'(m_iv));
      check("q_cnt", 32'(q_cnt), 32'(mq.size()));
      check("alloc_rdy", 32'(alloc_rdy), 32'(exp_ardy));
      if (m_iv) check("issue_dat_hold", 32'(issue_dat), 32'(m_idat));
      if (issue_v === 1'b1 && issue_rdy === 1'b1) begin
        if (expq.size() == 0) begin
          check("issue_unexpected", 32'(issue_dat), 32'hFFFF_FFFF);
        end else begin
          d = expq.pop_front();
          check("issue_dat", 32'(issue_dat), 32'(d));
        end
      end
    end
    check("final_q_cnt", 32'(q_cnt), 32'(0));
    check("final_sb_left", 32'(expq.size() + int'(m_iv)), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic cyc(input bit av, input logic [DW-1:0] d, input logic [TW-1:0] t,
                     input bit sr, input bit wv, input logic [TW-1:0] wt, input bit ir);
    @(negedge clk);
    #1;
    alloc_v       = av;
    alloc_dat     = d;
    alloc_tag     = t;
    alloc_src_rdy = sr;
    wake_v        = wv;
    wake_tag      = wt;
    issue_rdy     = ir;
`ifdef RV_ISSUE_FLUSH_EN
    flush         = 1'b0;
`endif
  endtask

  task automatic idle(input int n, input bit ir);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, ir);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_b   = 1'b0;
    alloc_v = 1'b0;
    wake_v  = 1'b0;
    @(negedge clk);
    #1;
    rst_b = 1'b1;
  endtask

`ifdef RV_ISSUE_FLUSH_EN
  task automatic flush_cyc();
    cyc(1'b1, 7'h55, 6'd1, 1'b1, 1'b1, 6'd1, 1'b1);
    flush = 1'b1;
  endtask
`endif

  initial begin
    rst_b = 1'b1;
    alloc_v = 1'b0; alloc_dat = '0; alloc_tag = '0; alloc_src_rdy = 1'b0;
    wake_v = 1'b0; wake_tag = '0; issue_rdy = 1'b0;
`ifdef RV_ISSUE_FLUSH_EN
    flush = 1'b0;
`endif
    #1 rst_b = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_b = 1'b1;
    idle(2, 1'b0);

    // Single ready alloc into an empty queue.
    cyc(1'b1, 7'h15, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1);
    idle(3, 1'b1);

    // Ready entry overtakes older waiters; wake releases the rest in age order.
    cyc(1'b1, 7'h0A, 6'd3, 1'b0, 1'b0, 6'd0, 1'b1);
    cyc(1'b1, 7'h0B, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1);
    cyc(1'b1, 7'h0C, 6'd3, 1'b0, 1'b0, 6'd0, 1'b1);
    idle(2, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 6'd3, 1'b1);
    idle(4, 1'b1);

    // Fill past capacity while stalled, then pop and alloc together.
    for (int i = 0; i < int'(QN) + 2; i++) cyc(1'b1, DW'(i + 32), 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(i + 100), 6'd0, 1'b1, 1'b0, 6'd0, 1'b1);
    idle(QN + 6, 1'b1);

    // Same-cycle wake bypass at alloc.
    cyc(1'b1, 7'h49, 6'd9, 1'b0, 1'b1, 6'd9, 1'b1);
    idle(3, 1'b1);

    // Long stall with ready entries, then release.
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(i + 64), 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
    idle(5, 1'b0);
    idle(9, 1'b1);

    // Reset in the middle of traffic.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(i + 80), 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
    do_reset();
    idle(3, 1'b1);

`ifdef RV_ISSUE_FLUSH_EN
    for (int i = 0; i < 11; i++) cyc(1'b1, DW'(i + 16), 6'd0, 1'b1, 1'b0, 6'd0, 1'b0);
    flush_cyc();
    idle(3, 1'b1);
`endif

    // Randomized traffic with alternating downstream pressure.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end
`ifdef RV_ISSUE_FLUSH_EN
      else if ($urandom_range(0, 199) == 0) begin
        flush_cyc();
      end
`endif
      else begin
        cyc($urandom_range(0, 99) < 60, DW'($urandom), TW'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            TW'($urandom_range(0, 7)),
            $urandom_range(0, 99) < (((n / 400) % 2 == 1) ? 85 : 40));
      end
    end

    // Drain: wake every tag in use, then let the issue stage empty.
    for (int t = 0; t < 16; t++) cyc(1'b0, '0, '0, 1'b0, 1'b1, TW'(t), 1'b1);
    idle(QN + 8, 1'b1);
    @(negedge clk);
    #1;
    done = 1'b1;
  end

endmodule
